// File: rtl/byte_striping.sv
// byte_striping: distributes an incoming byte stream round-robin across four
// output lanes. Complete groups of four bytes are emitted together. A gap in
// the stream flushes a partial group, with the unfilled lanes set to PAD_SYM.
module byte_striping #(
   parameter int          LANES   = 4,
   parameter logic [7:0]  PAD_SYM = 8'h7C
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic [7:0] tx_multiplexada,
   input  logic       tx_Valid,
   output logic [7:0] lane0,
   output logic [7:0] lane1,
   output logic [7:0] lane2,
   output logic [7:0] lane3,
   output logic       lanes_valid,
   output logic       padded,
   output logic [7:0] group_cnt
);

   // Slot index of the last lane in a group; the design is built for four lanes.
   localparam logic [1:0] LAST_SLOT = 2'(LANES - 1);

   logic [1:0] idx;
   logic [7:0] hold0;
   logic [7:0] hold1;
   logic [7:0] hold2;

   logic       accept;
   logic       group_done;
   logic       flush;
   logic       emit;
   logic [7:0] flush_lane1;
   logic [7:0] flush_lane2;

   // Decode what happens at the coming edge: fill a slot, complete a group, or flush a partial one.
   always_comb begin
      accept     = enb & tx_Valid;
      group_done = accept & (idx == LAST_SLOT);
      flush      = enb & ~tx_Valid & (idx != 2'd0);
      emit       = group_done | flush;
   end

   // Select lane contents for a partial group: lanes at or beyond idx get the pad byte.
   // Lane 0 always holds a real byte in a flush, and lane 3 is always padding.
   always_comb begin
      flush_lane1 = PAD_SYM;
      flush_lane2 = PAD_SYM;
      if (idx >= 2'd2) begin
         flush_lane1 = hold1;
      end
      if (idx == 2'd3) begin
         flush_lane2 = hold2;
      end
   end

   // Advance the round-robin slot on every accepted byte, and restart at slot 0 once a group goes out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= 2'd0;
      end else if (emit) begin
         idx <= 2'd0;
      end else if (accept) begin
         idx <= idx + 2'd1;
      end
   end

   // Keep the bytes for slots 0..2 until the group completes or gets flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold0 <= 8'h00;
         hold1 <= 8'h00;
         hold2 <= 8'h00;
      end else if (accept && !group_done) begin
         case (idx)
            2'd0:    hold0 <= tx_multiplexada;
            2'd1:    hold1 <= tx_multiplexada;
            default: hold2 <= tx_multiplexada;
         endcase
      end
   end

   // Load the lane outputs only when a group is emitted. At all other times they hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane0 <= 8'h00;
         lane1 <= 8'h00;
         lane2 <= 8'h00;
         lane3 <= 8'h00;
      end else if (group_done) begin
         lane0 <= hold0;
         lane1 <= hold1;
         lane2 <= hold2;
         lane3 <= tx_multiplexada;
      end else if (flush) begin
         lane0 <= hold0;
         lane1 <= flush_lane1;
         lane2 <= flush_lane2;
         lane3 <= PAD_SYM;
      end
   end

   // Pulse the group flags for one cycle per emitted group, and count groups modulo 256.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_valid <= 1'b0;
         padded      <= 1'b0;
         group_cnt   <= 8'h00;
      end else begin
         lanes_valid <= emit;
         padded      <= flush;
         if (emit) begin
            group_cnt <= group_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_byte_striping.sv
// Testbench for byte_striping: directed scenarios plus a randomized stream,
// all checked each cycle against a queue-based model of the striping rules.
module tb_byte_striping;

   localparam logic [7:0] PAD = 8'h7C;

   logic       clk;
   logic       rst;
   logic       enb;
   logic [7:0] tx_multiplexada;
   logic       tx_Valid;
   logic [7:0] lane0;
   logic [7:0] lane1;
   logic [7:0] lane2;
   logic [7:0] lane3;
   logic       lanes_valid;
   logic       padded;
   logic [7:0] group_cnt;

   int num_checks;
   int num_errors;

   // Reference model state: bytes waiting for a group, plus the expected outputs.
   logic [7:0] m_q[$];
   logic [7:0] m_lanes[4];
   logic       m_valid;
   logic       m_padded;
   logic [7:0] m_cnt;

   byte_striping #(.LANES(4), .PAD_SYM(PAD)) dut (
      .clk(clk),
      .rst(rst),
      .enb(enb),
      .tx_multiplexada(tx_multiplexada),
      .tx_Valid(tx_Valid),
      .lane0(lane0),
      .lane1(lane1),
      .lane2(lane2),
      .lane3(lane3),
      .lanes_valid(lanes_valid),
      .padded(padded),
      .group_cnt(group_cnt)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelEmit(input logic is_pad);
      for (int i = 0; i < 4; i++) begin
         m_lanes[i] = (i < m_q.size()) ? m_q[i] : PAD;
      end
      m_valid  = 1'b1;
      m_padded = is_pad;
      m_cnt    = m_cnt + 8'd1;
      m_q.delete();
   endtask

   task automatic modelEdge(input logic e, input logic v, input logic [7:0] d);
      m_valid  = 1'b0;
      m_padded = 1'b0;
      if (e) begin
         if (v) begin
            m_q.push_back(d);
            if (m_q.size() == 4) modelEmit(1'b0);
         end else if (m_q.size() > 0) begin
            modelEmit(1'b1);
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("lanes", {lane0, lane1, lane2, lane3},
                  {m_lanes[0], m_lanes[1], m_lanes[2], m_lanes[3]});
      checkOutput("lanes_valid", 32'(lanes_valid), 32'(m_valid));
      checkOutput("padded", 32'(padded), 32'(m_padded));
      checkOutput("group_cnt", 32'(group_cnt), 32'(m_cnt));
   endtask

   // Called at a negedge: drive the inputs, take one rising edge, and compare #1 later.
   task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d);
      enb             = e;
      tx_Valid        = v;
      tx_multiplexada = d;
      @(posedge clk);
      modelEdge(e, v, d);
      #1;
      checkAll();
      @(negedge clk);
   endtask

   // Called at a negedge: assert reset asynchronously, check the cleared outputs, then release it.
   task automatic doReset();
      rst = 1'b1;
      #2;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_lanes[i] = 8'h00;
      m_valid  = 1'b0;
      m_padded = 1'b0;
      m_cnt    = 8'h00;
      checkOutput("reset_lanes", {lane0, lane1, lane2, lane3}, 32'h0);
      checkOutput("reset_flags", {30'b0, lanes_valid, padded}, 32'h0);
      checkOutput("reset_cnt", 32'(group_cnt), 32'h0);
      @(posedge clk);
      #1;
      checkAll();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] bytes4[4];
      num_checks      = 0;
      num_errors      = 0;
      rst             = 1'b0;
      enb             = 1'b0;
      tx_Valid        = 1'b0;
      tx_multiplexada = 8'h00;
      m_cnt           = 8'h00;
      @(negedge clk);
      doReset();

      // Full group
      bytes4 = '{8'hBC, 8'hFB, 8'h11, 8'h22};
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, bytes4[i]);
      checkOutput("full_group_lanes", {lane0, lane1, lane2, lane3}, 32'hBCFB1122);
      checkOutput("full_group_flags", {29'b0, lanes_valid, padded, group_cnt[0]}, 32'b101);
      applyStimulus(1'b1, 1'b0, 8'h00);

      // Flush of three bytes
      applyStimulus(1'b1, 1'b1, 8'hFB);
      applyStimulus(1'b1, 1'b1, 8'hFF);
      applyStimulus(1'b1, 1'b1, 8'hFF);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("flush3_lanes", {lane0, lane1, lane2, lane3}, 32'hFBFFFF7C);
      checkOutput("flush3_flags", {30'b0, lanes_valid, padded}, 32'b11);

      // Flushes of one and two bytes
      applyStimulus(1'b1, 1'b1, 8'hA1);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("flush1_lanes", {lane0, lane1, lane2, lane3}, 32'hA17C7C7C);
      applyStimulus(1'b1, 1'b1, 8'hB1);
      applyStimulus(1'b1, 1'b1, 8'hB2);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("flush2_lanes", {lane0, lane1, lane2, lane3}, 32'hB1B27C7C);

      // Streaming 12 bytes back to back
      doReset();
      for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 1'b1, 8'(i));
      checkOutput("stream_lanes", {lane0, lane1, lane2, lane3}, 32'h090A0B0C);
      checkOutput("stream_cnt", 32'(group_cnt), 32'd3);

      // Enable stall with a byte offered while disabled
      applyStimulus(1'b1, 1'b1, 8'hAA);
      applyStimulus(1'b1, 1'b1, 8'hBB);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h55);
      applyStimulus(1'b1, 1'b1, 8'hCC);
      applyStimulus(1'b1, 1'b1, 8'hDD);
      checkOutput("stall_lanes", {lane0, lane1, lane2, lane3}, 32'hAABBCCDD);

      // Reset in the middle of a group
      applyStimulus(1'b1, 1'b1, 8'h91);
      applyStimulus(1'b1, 1'b1, 8'h92);
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'h1C);
      checkOutput("midreset_lanes", {lane0, lane1, lane2, lane3}, 32'h1C1C1C1C);
      checkOutput("midreset_flags", {22'b0, lanes_valid, padded, group_cnt}, {22'b0, 2'b10, 8'd1});

      // Counter wrap over 256 groups
      doReset();
      for (int g = 0; g < 256; g++) begin
         for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'(g + i));
      end
      checkOutput("wrap_cnt", 32'(group_cnt), 32'd0);
      checkOutput("wrap_valid", 32'(lanes_valid), 32'd1);
      checkOutput("wrap_lanes", {lane0, lane1, lane2, lane3}, 32'hFF000102);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_errors);
      $finish;
   end

endmodule

// File: doc/byte_striping.md
BYTE_STRIPING -- requirements
Module: byte_striping

Interface
REQ-001 The block SHALL have parameter LANES, default 4, the fixed number of output lanes; only the value 4 is supported.
REQ-002 The block SHALL have parameter PAD_SYM, default 8'h7C (IDLE K-symbol), the fill byte for unfilled lanes.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port enb, input, 1 bit: block enable; when low, all state holds.
REQ-006 Port tx_multiplexada, input, 8 bits: byte stream from the upstream multiplexer.
REQ-007 Port tx_Valid, input, 1 bit: tx_multiplexada carries a valid byte this cycle.
REQ-008 Ports lane0, lane1, lane2, lane3, each output, 8 bits, registered: striped bytes for lanes 0..3.
REQ-009 Port lanes_valid, output, 1 bit, registered: lane0..lane3 hold a new group this cycle (one-cycle pulse per group).
REQ-010 Port padded, output, 1 bit, registered: the current group contains one or more PAD_SYM fill bytes.
REQ-011 Port group_cnt, output, 8 bits, registered: number of groups emitted, modulo 256.

Function
REQ-012 A byte SHALL be accepted on a rising edge only when enb=1 and tx_Valid=1.
REQ-013 Accepted bytes SHALL be assigned round-robin: the 1st, 2nd, 3rd and 4th bytes of a group go to lanes 0, 1, 2 and 3, tracked by a 2-bit slot index idx (0..3).
REQ-014 Bytes for slots 0..2 SHALL be stored in internal holding registers; outputs SHALL not change when slots 0..2 are filled.
REQ-015 On acceptance with idx=3, the block SHALL load lane0..lane2 from the holding registers and lane3 from tx_multiplexada at that same edge.
REQ-016 That load SHALL set lanes_valid=1 and padded=0 for the following cycle, increment group_cnt, and return idx to 0.
REQ-017 Latency from acceptance of a group's 4th byte to lanes_valid=1 SHALL be exactly one clock edge.
REQ-018 Flush: on an edge with enb=1, tx_Valid=0 and idx!=0, the block SHALL emit the partial group.
REQ-019 In a flush, lanes with slot < idx SHALL carry held bytes and lanes with slot >= idx SHALL carry PAD_SYM.
REQ-020 A flush SHALL set lanes_valid=1 and padded=1, increment group_cnt, and return idx to 0.
REQ-021 With enb=1, tx_Valid=0 and idx=0, the block SHALL do nothing: lanes hold, lanes_valid=0, padded=0.
REQ-022 On every edge that does not emit a group, lanes_valid SHALL be 0 and lane0..lane3 SHALL hold their previous values.
REQ-023 With enb=0, idx, the holding registers, lanes and group_cnt SHALL hold, and lanes_valid and padded SHALL be 0 on the next edge; any tx_Valid is ignored.
REQ-024 Back-to-back groups (tx_Valid=1 continuously) SHALL produce lanes_valid=1 every 4th cycle with no byte lost or duplicated.
REQ-025 group_cnt SHALL wrap from 255 to 0 without affecting any other output.
REQ-026 Byte values SHALL pass unmodified; K-symbols (8'hBC, 8'hFB, 8'hFD, etc.) receive no special treatment.

Reset
REQ-027 While rst=1, regardless of clk: lane0..lane3=8'h00, lanes_valid=0, padded=0, group_cnt=0, idx=0, holding registers=8'h00.
REQ-028 Reset asserted mid-group SHALL discard the partial group; no flush is emitted on release.
REQ-029 The first byte accepted after reset release SHALL go to lane 0.

Verification
REQ-030 Full group: rst then enb=1, tx_Valid=1, bytes BC,FB,11,22 on 4 edges -> next cycle lane0..3=BC,FB,11,22, lanes_valid=1, padded=0, group_cnt=1.
REQ-031 Flush: bytes FB,FF,FF then tx_Valid=0 -> next cycle lanes=FB,FF,FF,7C, lanes_valid=1, padded=1.
REQ-032 Streaming: 12 consecutive bytes 01..0C -> three lanes_valid pulses, 4 cycles apart, groups 01-04, 05-08, 09-0C; group_cnt=3.
REQ-033 Enable stall: enb=0 for 3 cycles after 2 accepted bytes (AA,BB), tx_Valid=1 with byte 55 during the stall, then CC,DD with enb=1 -> lanes=AA,BB,CC,DD; 55 absent.
REQ-034 Reset mid-group: accept 2 bytes, pulse rst, then send 1C,1C,1C,1C -> all outputs 0 during reset; first group is 1C x4 with padded=0 and group_cnt=1.
REQ-035 Wrap: emit 256 groups -> group_cnt reads 0 after the 256th group, and lanes and lanes_valid behave normally.
